// File: rtl/vga_timing_pkg.sv
// Shared helpers and types for the VGA raster engine: line/frame totals, counter widths,
// per-channel colour enables and sync polarity.
package vga_timing_pkg;

    localparam int unsigned PIX_COORD_W = 10;
    localparam int unsigned UF_CNT_W    = 16;

    typedef enum logic {
        SYNC_ACTIVE_LOW  = 1'b0,
        SYNC_ACTIVE_HIGH = 1'b1
    } sync_pol_e;

    typedef struct packed {
        logic r;
        logic g;
        logic b;
    } rgb_on_t;

    function automatic int unsigned h_total(input int unsigned active, input int unsigned front,
                                            input int unsigned sync, input int unsigned back);
        return active + front + sync + back;
    endfunction

    function automatic int unsigned v_total(input int unsigned active, input int unsigned front,
                                            input int unsigned sync, input int unsigned back);
        return active + front + sync + back;
    endfunction

    function automatic int unsigned cnt_width(input int unsigned total);
        return (total < 32'd2) ? 32'd1 : $clog2(total);
    endfunction

    // Bar k lights R/G/B from bits 2/1/0 of its index.
    function automatic rgb_on_t bar_color(input logic [2:0] k);
        rgb_on_t c;
        c.r = k[2];
        c.g = k[1];
        c.b = k[0];
        return c;
    endfunction

endpackage

// File: rtl/vga_sync_counter.sv
// Pixel-tick divider, horizontal/vertical raster counters and the stage-0 region decode.
module vga_sync_counter
    import vga_timing_pkg::*;
#(
    parameter int unsigned H_ACTIVE = 640,
    parameter int unsigned H_FRONT  = 16,
    parameter int unsigned H_SYNC   = 96,
    parameter int unsigned H_BACK   = 48,
    parameter int unsigned V_ACTIVE = 480,
    parameter int unsigned V_FRONT  = 11,
    parameter int unsigned V_SYNC   = 2,
    parameter int unsigned V_BACK   = 31,
    parameter int unsigned CLK_DIV  = 2,
    localparam int unsigned H_W = cnt_width(h_total(H_ACTIVE, H_FRONT, H_SYNC, H_BACK)),
    localparam int unsigned V_W = cnt_width(v_total(V_ACTIVE, V_FRONT, V_SYNC, V_BACK))
) (
    input  logic           clk_i,
    input  logic           rst_ni,
    input  logic           enable_i,
    output logic           tick_o,
    output logic           pclk_o,
    output logic [H_W-1:0] h_o,
    output logic [V_W-1:0] v_o,
    output logic           active_o,
    output logic           hs_o,
    output logic           vs_o,
    output logic           first_o
);

    localparam int unsigned H_TOTAL = h_total(H_ACTIVE, H_FRONT, H_SYNC, H_BACK);
    localparam int unsigned V_TOTAL = v_total(V_ACTIVE, V_FRONT, V_SYNC, V_BACK);
    localparam int unsigned DIV_W   = cnt_width(CLK_DIV);

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(CLK_DIV / 2);
    localparam logic [H_W-1:0]   H_LAST   = H_W'(H_TOTAL - 1);
    localparam logic [V_W-1:0]   V_LAST   = V_W'(V_TOTAL - 1);
    localparam logic [H_W-1:0]   H_ACT    = H_W'(H_ACTIVE);
    localparam logic [V_W-1:0]   V_ACT    = V_W'(V_ACTIVE);
    localparam logic [H_W-1:0]   HS_BEGIN = H_W'(H_ACTIVE + H_FRONT);
    localparam logic [H_W-1:0]   HS_END   = H_W'(H_ACTIVE + H_FRONT + H_SYNC);
    localparam logic [V_W-1:0]   VS_BEGIN = V_W'(V_ACTIVE + V_FRONT);
    localparam logic [V_W-1:0]   VS_END   = V_W'(V_ACTIVE + V_FRONT + V_SYNC);

    logic [DIV_W-1:0] div_q, div_d;
    logic [H_W-1:0]   h_q, h_d;
    logic [V_W-1:0]   v_q, v_d;

    assign tick_o   = (div_q == DIV_LAST) && enable_i;
    assign pclk_o   = (div_q < DIV_HALF);
    assign h_o      = h_q;
    assign v_o      = v_q;
    assign active_o = (h_q < H_ACT) && (v_q < V_ACT);
    assign hs_o     = (h_q >= HS_BEGIN) && (h_q < HS_END);
    assign vs_o     = (v_q >= VS_BEGIN) && (v_q < VS_END);
    assign first_o  = (h_q == {H_W{1'b0}}) && (v_q == {V_W{1'b0}});

    // Next divider/raster position; nothing moves while enable is low.
    always_comb begin
        div_d = div_q;
        h_d   = h_q;
        v_d   = v_q;
        if (!enable_i) begin
            div_d = div_q;
        end else if (div_q == DIV_LAST) begin
            div_d = {DIV_W{1'b0}};
        end else begin
            div_d = div_q + DIV_W'(1);
        end
        if (tick_o) begin
            if (h_q == H_LAST) begin
                h_d = {H_W{1'b0}};
                if (v_q == V_LAST) begin
                    v_d = {V_W{1'b0}};
                end else begin
                    v_d = v_q + V_W'(1);
                end
            end else begin
                h_d = h_q + H_W'(1);
            end
        end else begin
            h_d = h_q;
        end
    end

    // Divider and raster counter registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            div_q <= {DIV_W{1'b0}};
            h_q   <= {H_W{1'b0}};
            v_q   <= {V_W{1'b0}};
        end else begin
            div_q <= div_d;
            h_q   <= h_d;
            v_q   <= v_d;
        end
    end

endmodule

// File: rtl/vga_timing_generator.sv
// VGA raster engine: issues pixel fetches, realigns returned colour with delayed sync/blank.
// Optional colour-bar generator enabled by defining VGA_TEST_PATTERN_EN.
module vga_timing_generator
    import vga_timing_pkg::*;
#(
    parameter int unsigned H_ACTIVE      = 640,
    parameter int unsigned H_FRONT       = 16,
    parameter int unsigned H_SYNC        = 96,
    parameter int unsigned H_BACK        = 48,
    parameter int unsigned V_ACTIVE      = 480,
    parameter int unsigned V_FRONT       = 11,
    parameter int unsigned V_SYNC        = 2,
    parameter int unsigned V_BACK        = 31,
    parameter sync_pol_e   HSYNC_POL     = SYNC_ACTIVE_LOW,
    parameter sync_pol_e   VSYNC_POL     = SYNC_ACTIVE_LOW,
    parameter int unsigned CLK_DIV       = 2,
    parameter int unsigned COLOR_BITS    = 4,
    parameter int unsigned FETCH_LATENCY = 2
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    enable,
`ifdef VGA_TEST_PATTERN_EN
    input  logic                    pattern_sel,
`endif
    output logic                    pix_req,
    output logic [PIX_COORD_W-1:0]  pix_x,
    output logic [PIX_COORD_W-1:0]  pix_y,
    input  logic [3*COLOR_BITS-1:0] pix_data,
    input  logic                    pix_valid,
    output logic [COLOR_BITS-1:0]   VGA_R,
    output logic [COLOR_BITS-1:0]   VGA_G,
    output logic [COLOR_BITS-1:0]   VGA_B,
    output logic                    VGA_HSYNC,
    output logic                    VGA_VSYNC,
    output logic                    VGA_PIXEL_CLOCK,
    output logic                    frame_start,
    output logic [UF_CNT_W-1:0]     underflow_count
);

    localparam int unsigned H_W   = cnt_width(h_total(H_ACTIVE, H_FRONT, H_SYNC, H_BACK));
    localparam int unsigned V_W   = cnt_width(v_total(V_ACTIVE, V_FRONT, V_SYNC, V_BACK));
    localparam int unsigned RGB_W = 3 * COLOR_BITS;
    localparam logic        HS_IDLE = ~HSYNC_POL;
    localparam logic        VS_IDLE = ~VSYNC_POL;

    typedef struct packed {
        logic active;
        logic hs;
        logic vs;
        logic first;
`ifdef VGA_TEST_PATTERN_EN
        logic [2:0] bar;
`endif
    } stage_t;

    logic           tick_s, pclk_s, active_s, hs_s, vs_s, first_s;
    logic [H_W-1:0] h_s;
    logic [V_W-1:0] v_s;
    stage_t         stage0_s, last_s;
    stage_t         pipe_q [FETCH_LATENCY];

    logic                   pix_req_q, pix_req_d;
    logic [PIX_COORD_W-1:0] pix_x_q, pix_x_d, pix_y_q, pix_y_d;
    logic [RGB_W-1:0]       rgb_q, rgb_d;
    logic                   hsync_q, hsync_d, vsync_q, vsync_d;
    logic                   pclk_q, pclk_d, frame_q, frame_d;
    logic [UF_CNT_W-1:0]    uf_q, uf_d;

    vga_sync_counter #(
        .H_ACTIVE (H_ACTIVE), .H_FRONT (H_FRONT), .H_SYNC (H_SYNC), .H_BACK (H_BACK),
        .V_ACTIVE (V_ACTIVE), .V_FRONT (V_FRONT), .V_SYNC (V_SYNC), .V_BACK (V_BACK),
        .CLK_DIV  (CLK_DIV)
    ) u_sync_counter (
        .clk_i    (clk),
        .rst_ni   (reset),
        .enable_i (enable),
        .tick_o   (tick_s),
        .pclk_o   (pclk_s),
        .h_o      (h_s),
        .v_o      (v_s),
        .active_o (active_s),
        .hs_o     (hs_s),
        .vs_o     (vs_s),
        .first_o  (first_s)
    );

    // Pack the stage-0 decode that travels alongside the fetch.
    always_comb begin
        stage0_s        = '0;
        stage0_s.active = active_s;
        stage0_s.hs     = hs_s;
        stage0_s.vs     = vs_s;
        stage0_s.first  = first_s;
`ifdef VGA_TEST_PATTERN_EN
        stage0_s.bar    = 3'(h_s / H_W'(H_ACTIVE / 8));
`endif
    end

    assign last_s = pipe_q[FETCH_LATENCY-1];

    // Fetch-latency shift register, advancing once per pixel tick.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < FETCH_LATENCY; i++) pipe_q[i] <= '0;
        end else if (tick_s) begin
            pipe_q[0] <= stage0_s;
            for (int i = 1; i < FETCH_LATENCY; i++) pipe_q[i] <= pipe_q[i-1];
        end
    end

`ifdef VGA_TEST_PATTERN_EN
    rgb_on_t          bar_on_s;
    logic [RGB_W-1:0] pat_rgb_s;
    assign bar_on_s  = bar_color(last_s.bar);
    assign pat_rgb_s = {{COLOR_BITS{bar_on_s.r}}, {COLOR_BITS{bar_on_s.g}}, {COLOR_BITS{bar_on_s.b}}};
`endif

    // Request, output-stage and underflow next-state logic.
    always_comb begin
        pix_req_d = tick_s && active_s;
        pix_x_d   = pix_x_q;
        pix_y_d   = pix_y_q;
        rgb_d     = rgb_q;
        hsync_d   = hsync_q;
        vsync_d   = vsync_q;
        pclk_d    = enable && pclk_s;
        frame_d   = 1'b0;
        uf_d      = uf_q;
        if (pix_req_d) begin
            pix_x_d = PIX_COORD_W'(h_s);
            pix_y_d = PIX_COORD_W'(v_s);
        end else begin
            pix_x_d = pix_x_q;
        end
        if (!enable) begin
            rgb_d   = {RGB_W{1'b0}};
            hsync_d = HS_IDLE;
            vsync_d = VS_IDLE;
        end else if (tick_s) begin
            hsync_d = last_s.hs ~^ HSYNC_POL;
            vsync_d = last_s.vs ~^ VSYNC_POL;
            frame_d = last_s.first;
            if (!last_s.active) begin
                rgb_d = {RGB_W{1'b0}};
`ifdef VGA_TEST_PATTERN_EN
            end else if (pattern_sel) begin
                rgb_d = pat_rgb_s;
`endif
            end else if (pix_valid) begin
                rgb_d = pix_data;
            end else begin
                rgb_d = {RGB_W{1'b0}};
                uf_d  = (uf_q == 16'hFFFF) ? uf_q : uf_q + 16'd1;
            end
        end else begin
            rgb_d = rgb_q;
        end
    end

    // Output registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pix_req_q <= 1'b0;
            pix_x_q   <= {PIX_COORD_W{1'b0}};
            pix_y_q   <= {PIX_COORD_W{1'b0}};
            rgb_q     <= {RGB_W{1'b0}};
            hsync_q   <= HS_IDLE;
            vsync_q   <= VS_IDLE;
            pclk_q    <= 1'b0;
            frame_q   <= 1'b0;
            uf_q      <= {UF_CNT_W{1'b0}};
        end else begin
            pix_req_q <= pix_req_d;
            pix_x_q   <= pix_x_d;
            pix_y_q   <= pix_y_d;
            rgb_q     <= rgb_d;
            hsync_q   <= hsync_d;
            vsync_q   <= vsync_d;
            pclk_q    <= pclk_d;
            frame_q   <= frame_d;
            uf_q      <= uf_d;
        end
    end

    assign pix_req         = pix_req_q;
    assign pix_x           = pix_x_q;
    assign pix_y           = pix_y_q;
    assign VGA_R           = rgb_q[3*COLOR_BITS-1:2*COLOR_BITS];
    assign VGA_G           = rgb_q[2*COLOR_BITS-1:COLOR_BITS];
    assign VGA_B           = rgb_q[COLOR_BITS-1:0];
    assign VGA_HSYNC       = hsync_q;
    assign VGA_VSYNC       = vsync_q;
    assign VGA_PIXEL_CLOCK = pclk_q;
    assign frame_start     = frame_q;
    assign underflow_count = uf_q;

endmodule
